// File: rtl/keypad_digit_capture.sv
// 4x4 keypad scanner: rotates an active-low column, debounces press and release, and keeps
// the last two accepted hex keys. Define ROW_SYNC_EN to pass rows through a 2-flop synchronizer.
module keypad_digit_capture #(
    parameter int unsigned SCAN_CYCLES     = 24000,
    parameter int unsigned DEBOUNCE_CYCLES = 480000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic       key_valid
);

    localparam int unsigned SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DEB_DONE  = DW'(DEBOUNCE_CYCLES);

    localparam logic [1:0] SCAN             = 2'd0;
    localparam logic [1:0] DEBOUNCE_PRESS   = 2'd1;
    localparam logic [1:0] HELD             = 2'd2;
    localparam logic [1:0] DEBOUNCE_RELEASE = 2'd3;

    logic [3:0] rows_s;

`ifdef ROW_SYNC_EN
    logic [3:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= rows;
            sync2_q <= sync1_q;
        end
    end

    assign rows_s = sync2_q;
`else
    assign rows_s = rows;
`endif

    logic [1:0]    state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [3:0]    pat_q, pat_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    new_d, old_d;
    logic          valid_d;

    logic [3:0] rows_low;
    logic       one_low;
    logic [1:0] row_idx;

    // A press is only taken when exactly one row is pulled low.
    assign rows_low = ~rows_s;
    assign one_low  = (rows_low != 4'h0) && ((rows_low & (rows_low - 4'd1)) == 4'h0);

    always_comb begin
        row_idx = 2'd0;
        if (rows_low[1]) row_idx = 2'd1;
        if (rows_low[2]) row_idx = 2'd2;
        if (rows_low[3]) row_idx = 2'd3;
    end

    function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        unique case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        scan_d  = scan_q;
        deb_d   = deb_q;
        pat_d   = pat_q;
        row_d   = row_q;
        new_d   = digit_new;
        old_d   = digit_old;
        valid_d = 1'b0;
        unique case (state_q)
            SCAN: begin
                if (scan_q == SCAN_LAST) begin
                    scan_d = '0;
                    if (one_low) begin
                        pat_d   = rows_s;
                        row_d   = row_idx;
                        deb_d   = '0;
                        state_d = DEBOUNCE_PRESS;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            DEBOUNCE_PRESS: begin
                if (rows_s != pat_q) begin
                    deb_d   = '0;
                    col_d   = col_q + 2'd1;
                    state_d = SCAN;
                end else if (deb_q == DEB_DONE) begin
                    old_d   = digit_new;
                    new_d   = decode(row_q, col_q);
                    valid_d = 1'b1;
                    deb_d   = '0;
                    state_d = HELD;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            HELD: begin
                if (rows_s == 4'hF) begin
                    deb_d   = '0;
                    state_d = DEBOUNCE_RELEASE;
                end
            end
            default: begin
                if (rows_s != 4'hF) begin
                    deb_d   = '0;
                    state_d = HELD;
                end else if (deb_q == DEB_DONE) begin
                    deb_d   = '0;
                    scan_d  = '0;
                    col_d   = col_q + 2'd1;
                    state_d = SCAN;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SCAN;
            col_q     <= 2'd0;
            scan_q    <= '0;
            deb_q     <= '0;
            pat_q     <= 4'hF;
            row_q     <= 2'd0;
            digit_new <= 4'h0;
            digit_old <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            scan_q    <= scan_d;
            deb_q     <= deb_d;
            pat_q     <= pat_d;
            row_q     <= row_d;
            digit_new <= new_d;
            digit_old <= old_d;
            key_valid <= valid_d;
        end
    end

    assign cols = ~(4'b0001 << col_q);

endmodule

// File: tb/tb_keypad_digit_capture.sv
// Directed bench for keypad_digit_capture with SCAN_CYCLES=4, DEBOUNCE_CYCLES=8 and a
// behavioural keypad that pulls a row low while its key's column is driven.
module tb_keypad_digit_capture;

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic       key_valid;

    logic       press_en;
    logic [1:0] press_r;
    logic [1:0] press_c;
    logic       force_en;
    logic [3:0] force_rows;

    int tests;
    int fails;
    int pulses;

    keypad_digit_capture #(
        .SCAN_CYCLES    (4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rows     (rows),
        .cols     (cols),
        .digit_new(digit_new),
        .digit_old(digit_old),
        .key_valid(key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rows = 4'hF;
        if (force_en) rows = force_rows;
        else if (press_en && cols[press_c] == 1'b0) rows[press_r] = 1'b0;
    end

    always @(posedge clk) if (key_valid === 1'b1) pulses++;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cols(input logic [3:0] want);
        int n;
        n = 0;
        while (cols !== want && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_cols", {4'h0, cols}, {4'h0, want});
    endtask

    task automatic press_key(input logic [1:0] r, input logic [1:0] c);
        press_r  = r;
        press_c  = c;
        press_en = 1'b1;
        repeat (40) @(negedge clk);
        press_en = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    int            base;
    logic [3:0]    exp_c;
    logic [3:0]    c0;

    initial begin
        tests = 0; fails = 0; pulses = 0;
        press_en = 1'b0; press_r = 2'd0; press_c = 2'd0;
        force_en = 1'b0; force_rows = 4'hF;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_cols", {4'h0, cols}, 8'h0E);
        check("reset_new", {4'h0, digit_new}, 8'h00);
        check("reset_old", {4'h0, digit_old}, 8'h00);
        check("reset_valid", {7'h0, key_valid}, 8'h00);

        // Idle rotation: column k/4 after k edges from reset release
        reset = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            exp_c = ~(4'b0001 << ((k / 4) % 4));
            check("rotate_cols", {4'h0, cols}, {4'h0, exp_c});
            @(negedge clk);
        end
        check("idle_no_pulse", 8'(pulses), 8'd0);

        // Key '6' (row1, col2)
        wait_cols(4'b1011);
        press_key(2'd1, 2'd2);
        check("k6_pulses", 8'(pulses), 8'd1);
        check("k6_new", {4'h0, digit_new}, 8'h06);
        check("k6_old", {4'h0, digit_old}, 8'h00);

        // '5' then '9', then '9' again after full release
        press_key(2'd1, 2'd1);
        check("k5_new", {4'h0, digit_new}, 8'h05);
        press_key(2'd2, 2'd2);
        check("k59_pulses", 8'(pulses), 8'd3);
        check("k59_new", {4'h0, digit_new}, 8'h09);
        check("k59_old", {4'h0, digit_old}, 8'h05);
        press_key(2'd2, 2'd2);
        check("k99_pulses", 8'(pulses), 8'd4);
        check("k99_old", {4'h0, digit_old}, 8'h09);

        // Bouncing '1' (row0, col0) never yields a pulse until stable
        base = pulses;
        press_r = 2'd0; press_c = 2'd0;
        for (int i = 0; i < 10; i++) begin
            press_en = ~press_en;
            @(negedge clk);
        end
        check("bounce_no_pulse", 8'(pulses - base), 8'd0);
        press_en = 1'b1;
        repeat (8) @(negedge clk);
        check("bounce_early", 8'(pulses - base), 8'd0);
        repeat (40) @(negedge clk);
        press_en = 1'b0;
        repeat (20) @(negedge clk);
        check("bounce_pulses", 8'(pulses - base), 8'd1);
        check("k1_new", {4'h0, digit_new}, 8'h01);
        check("k1_old", {4'h0, digit_old}, 8'h09);

        // Two rows low: ignored, scanning continues
        base = pulses;
        force_en = 1'b1; force_rows = 4'b1100;
        repeat (40) @(negedge clk);
        c0 = cols;
        repeat (4) @(negedge clk);
        check("multi_rotate", {4'h0, cols}, {4'h0, c0[2:0], c0[3]});
        force_en = 1'b0;
        check("multi_no_pulse", 8'(pulses - base), 8'd0);
        check("multi_new", {4'h0, digit_new}, 8'h01);

        // Reset three cycles into debounce of 'A' (row0, col3)
        wait_cols(4'b1011);
        press_r = 2'd0; press_c = 2'd3; press_en = 1'b1;
        wait_cols(4'b0111);
        repeat (7) @(negedge clk);
        base = pulses;
        reset = 1'b1;
        #1;
        check("rst_mid_cols", {4'h0, cols}, 8'h0E);
        check("rst_mid_new", {4'h0, digit_new}, 8'h00);
        check("rst_mid_old", {4'h0, digit_old}, 8'h00);
        press_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("rst_no_pulse", 8'(pulses - base), 8'd0);
        press_key(2'd0, 2'd3);
        check("kA_pulses", 8'(pulses - base), 8'd1);
        check("kA_new", {4'h0, digit_new}, 8'h0A);
        check("kA_old", {4'h0, digit_old}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
